// File: rtl/tx_buffer_selecter.sv
// Packet-level arbiter merging NUM_BUFFERS tx buffers onto one registered flit stream.
// Grant is held until the tail is accepted; over-length packets are truncated and flagged.
module tx_buffer_selecter #(
  parameter int unsigned NUM_BUFFERS      = 4,
  parameter int unsigned FLIT_WIDTH       = 64,
  parameter int unsigned MAX_PACKET_FLITS = 8,
  parameter int unsigned ROUND_ROBIN      = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_BUFFERS-1:0]             in_valid,
  input  logic [NUM_BUFFERS*FLIT_WIDTH-1:0]  in_flit,
  input  logic [NUM_BUFFERS-1:0]             in_tail,
  output logic [NUM_BUFFERS-1:0]             in_ready,
  output logic                               out_valid,
  output logic [FLIT_WIDTH-1:0]              out_flit,
  output logic                               out_tail,
  output logic [$clog2(NUM_BUFFERS)-1:0]     out_src,
  input  logic                               out_ready,
  output logic                               err_overlength
);

  localparam int unsigned SRC_W = $clog2(NUM_BUFFERS);
  localparam int unsigned CNT_W = $clog2(MAX_PACKET_FLITS + 1);
  localparam int unsigned SUM_W = SRC_W + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q;
  logic [SRC_W-1:0]      grant_q;
  logic [SRC_W-1:0]      rr_ptr_q;
  logic [SRC_W-1:0]      rr_ptr_d;
  logic [CNT_W-1:0]      flit_cnt_q;
  logic [CNT_W-1:0]      flit_cnt_d;
  logic                  out_valid_q;
  logic [FLIT_WIDTH-1:0] out_flit_q;
  logic                  out_tail_q;
  logic [SRC_W-1:0]      out_src_q;
  logic                  err_q;

  logic                  win_found;
  logic [SRC_W-1:0]      win_idx;
  logic [SUM_W-1:0]      scan_idx;
  logic [SRC_W-1:0]      sel;
  logic                  sel_ok;
  logic                  stage_free;
  logic                  xfer;
  logic                  sel_tail;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  trunc;
  logic                  eff_tail;

  // Arbitration: scan from rr_ptr with explicit wrap (round-robin) or from index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_BUFFERS; k++) begin
      if (ROUND_ROBIN != 0) begin
        scan_idx = {1'b0, rr_ptr_q} + SUM_W'(k);
        if (scan_idx >= SUM_W'(NUM_BUFFERS)) begin
          scan_idx = scan_idx - SUM_W'(NUM_BUFFERS);
        end
      end else begin
        scan_idx = SUM_W'(k);
      end
      if (!win_found && in_valid[scan_idx[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[SRC_W-1:0];
      end
    end
  end

  assign stage_free = !out_valid_q || out_ready;
  assign sel        = (state_q == LOCKED) ? grant_q : win_idx;
  assign sel_ok     = (state_q == LOCKED) || win_found;

  always_comb begin
    in_ready = '0;
    if (!rst && stage_free && sel_ok) begin
      in_ready[sel] = 1'b1;
    end
  end

  assign xfer     = |(in_valid & in_ready);
  assign sel_tail = in_tail[sel];
  assign sel_flit = in_flit[32'(sel)*FLIT_WIDTH +: FLIT_WIDTH];

  // flit_cnt is zero in IDLE, so this also truncates a non-tail head when MAX_PACKET_FLITS is 1.
  assign trunc    = xfer && !sel_tail && (flit_cnt_q == CNT_W'(MAX_PACKET_FLITS - 1));
  assign eff_tail = sel_tail || trunc;

  assign rr_ptr_d   = (sel == SRC_W'(NUM_BUFFERS - 1)) ? '0 : sel + SRC_W'(1);
  assign flit_cnt_d = flit_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      flit_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_tail_q  <= 1'b0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= trunc;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= sel_flit;
        out_tail_q  <= eff_tail;
        out_src_q   <= sel;
        if (eff_tail) begin
          state_q    <= IDLE;
          flit_cnt_q <= '0;
          rr_ptr_q   <= rr_ptr_d;
        end else begin
          state_q    <= LOCKED;
          grant_q    <= sel;
          flit_cnt_q <= flit_cnt_d;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_flit       = out_flit_q;
  assign out_tail       = out_tail_q;
  assign out_src        = out_src_q;
  assign err_overlength = err_q;

endmodule

// File: tb/tb_tx_buffer_selecter.sv
// Bench for tx_buffer_selecter: per-buffer source queues, a packet-level ownership model
// and an expected-output scoreboard; one round-robin and one fixed-priority instance.
module tb_tx_buffer_selecter;

  localparam int unsigned NB  = 4;
  localparam int unsigned FW  = 16;
  localparam int unsigned MAX = 4;
  localparam int unsigned SW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] in_valid;
  logic [NB-1:0] in_tail;
  logic [NB*FW-1:0] in_flit;
  logic          out_ready;

  logic [NB-1:0] rr_in_ready, fp_in_ready;
  logic          rr_out_valid, fp_out_valid, rr_out_tail, fp_out_tail, rr_err, fp_err;
  logic [FW-1:0] rr_out_flit, fp_out_flit;
  logic [SW-1:0] rr_out_src, fp_out_src;

  always #5 clk = ~clk;

  tx_buffer_selecter #(.NUM_BUFFERS(NB), .FLIT_WIDTH(FW), .MAX_PACKET_FLITS(MAX), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_tail(in_tail),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_flit(rr_out_flit), .out_tail(rr_out_tail),
    .out_src(rr_out_src), .out_ready(out_ready), .err_overlength(rr_err));

  tx_buffer_selecter #(.NUM_BUFFERS(NB), .FLIT_WIDTH(FW), .MAX_PACKET_FLITS(MAX), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_tail(in_tail),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_flit(fp_out_flit), .out_tail(fp_out_tail),
    .out_src(fp_out_src), .out_ready(out_ready), .err_overlength(fp_err));

  bit fp_mode = 1'b0;
  logic [NB-1:0] rdy;
  logic          o_valid, o_tail, o_err;
  logic [FW-1:0] o_flit;
  logic [SW-1:0] o_src;
  assign rdy     = fp_mode ? fp_in_ready  : rr_in_ready;
  assign o_valid = fp_mode ? fp_out_valid : rr_out_valid;
  assign o_flit  = fp_mode ? fp_out_flit  : rr_out_flit;
  assign o_tail  = fp_mode ? fp_out_tail  : rr_out_tail;
  assign o_src   = fp_mode ? fp_out_src   : rr_out_src;
  assign o_err   = fp_mode ? fp_err       : rr_err;

  typedef struct packed {
    logic [FW-1:0] flit;
    logic          tail;
    logic [SW-1:0] src;
  } exp_t;

  logic [FW-1:0] sq_flit [NB][$];
  bit            sq_tail [NB][$];
  exp_t          exp_q[$];
  int            seen_src[$];
  bit            seen_tail[$];

  bit m_locked;
  int m_owner, m_cnt, m_ptr;
  int err_cnt;
  bit prev_stall;
  logic [FW-1:0] h_flit;
  logic h_tail;
  logic [SW-1:0] h_src;
  bit chk_fp3 = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push_pkt(input int b, input int len);
    for (int j = 0; j < len; j++) begin
      sq_flit[b].push_back(FW'($urandom));
      sq_tail[b].push_back(j == len - 1);
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NB; i++) if (sq_flit[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level arbitration rule over buffers that currently hold flits.
  function automatic int winner();
    for (int k = 0; k < NB; k++) begin
      int i;
      i = fp_mode ? k : (m_ptr + k) % NB;
      if (sq_flit[i].size() != 0) return i;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NB; i++) begin
      in_valid[i] = sq_flit[i].size() != 0;
      in_flit[i*FW +: FW] = in_valid[i] ? sq_flit[i][0] : '0;
      in_tail[i] = in_valid[i] ? sq_tail[i][0] : 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) begin
      sq_flit[i].delete();
      sq_tail[i].delete();
    end
    exp_q.delete();
    seen_src.delete();
    seen_tail.delete();
    m_locked = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    prev_stall = 1'b0;
  endtask

  task automatic step(input bit ordy);
    exp_t e;
    logic [NB-1:0] acc;
    int b;
    bit exp_err;
    @(negedge clk);
    out_ready = ordy;
    drive_inputs();
    #1;
    chk("ready_onehot0", $onehot0(rdy), 1);
    if (o_valid && !ordy) chk("ready_backpressure", rdy, 0);
    if (chk_fp3 && sq_flit[1].size() != 0) chk("fp_ready3", rdy[3], 0);
    if (prev_stall) begin
      chk("hold_flit", o_flit, h_flit);
      chk("hold_tail", o_tail, h_tail);
      chk("hold_src", o_src, h_src);
    end
    prev_stall = o_valid && !ordy;
    h_flit = o_flit; h_tail = o_tail; h_src = o_src;
    if (o_valid && ordy) begin
      chk("out_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_flit", o_flit, e.flit);
        chk("out_tail", o_tail, e.tail);
        chk("out_src", o_src, e.src);
        seen_src.push_back(int'(o_src));
        seen_tail.push_back(o_tail);
      end
    end
    acc = in_valid & rdy;
    b = -1;
    exp_err = 1'b0;
    for (int i = 0; i < NB; i++) if (acc[i] && b < 0) b = i;
    if (b >= 0) begin
      if (!m_locked) begin
        m_owner = winner();
        m_cnt = 0;
      end
      chk("accepted_buffer", b, m_owner);
      if (m_owner >= 0 && sq_flit[m_owner].size() != 0) begin
        m_cnt++;
        exp_err = !sq_tail[m_owner][0] && (m_cnt == MAX);
        e.flit = sq_flit[m_owner][0];
        e.tail = sq_tail[m_owner][0] || exp_err;
        e.src  = SW'(m_owner);
        exp_q.push_back(e);
        if (e.tail) begin
          m_locked = 1'b0;
          m_ptr = (m_owner + 1) % NB;
        end else begin
          m_locked = 1'b1;
        end
      end
    end
    @(posedge clk);
    if (b >= 0) begin
      void'(sq_flit[b].pop_front());
      void'(sq_tail[b].pop_front());
    end
    #1;
    chk("err_overlength", o_err, exp_err);
    if (o_err) err_cnt++;
    if (b >= 0) chk("valid_after_accept", o_valid, 1);
  endtask

  task automatic drain(input bit rnd, output int n);
    n = 0;
    while (!(srcs_empty() && exp_q.size() == 0) && n < 2000) begin
      step(rnd ? ($urandom_range(3) != 0) : 1'b1);
      n++;
    end
    chk("drain_in_budget", n < 2000, 1);
    chk("idle_after_drain", o_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    drive_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_rr[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_lock[4] = '{2, 2, 2, 0};
    bit exp_ovl[7] = '{0, 0, 0, 1, 0, 0, 1};
    int exp_fp[8] = '{1, 1, 1, 1, 1, 3, 3, 3};

    rst = 1'b1;
    out_ready = 1'b0;
    clear_model();
    drive_inputs();
    #3;
    chk("reset_out_valid", o_valid, 0);
    chk("reset_out_flit", o_flit, 0);
    chk("reset_out_tail", o_tail, 0);
    chk("reset_out_src", o_src, 0);
    chk("reset_err", o_err, 0);
    chk("reset_in_ready", rdy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin fairness, full throughput.
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(1, 2); push_pkt(2, 2); push_pkt(3, 2);
    drain(1'b0, n);
    chk("rr_no_bubble_cycles", n, 11);
    chk("rr_seq_len", seen_src.size(), 10);
    for (int i = 0; i < 10 && i < seen_src.size(); i++) chk("rr_seq", seen_src[i], exp_rr[i]);

    // Packet lock: buffer 0 arrives after buffer 2's head.
    seen_src.delete();
    push_pkt(2, 3);
    step(1'b1);
    push_pkt(0, 1);
    drain(1'b0, n);
    chk("lock_seq_len", seen_src.size(), 4);
    for (int i = 0; i < 4 && i < seen_src.size(); i++) chk("lock_seq", seen_src[i], exp_lock[i]);

    // Backpressure mid-packet.
    seen_src.delete();
    push_pkt(3, 4);
    step(1'b1); step(1'b1);
    repeat (5) step(1'b0);
    drain(1'b0, n);
    chk("bp_flit_count", seen_src.size(), 4);

    // Over-length: 6 non-tail flits then a tail.
    seen_tail.delete();
    err_cnt = 0;
    for (int j = 0; j < 7; j++) begin
      sq_flit[1].push_back(FW'($urandom));
      sq_tail[1].push_back(j == 6);
    end
    drain(1'b1, n);
    chk("ovl_err_count", err_cnt, 1);
    chk("ovl_seq_len", seen_tail.size(), 7);
    for (int i = 0; i < 7 && i < seen_tail.size(); i++) chk("ovl_tail_seq", seen_tail[i], exp_ovl[i]);

    // Random traffic with random backpressure.
    repeat (20) begin
      for (int b = 0; b < NB; b++)
        repeat ($urandom_range(2)) push_pkt(b, $urandom_range(1, 6));
      drain(1'b1, n);
    end

    // Asynchronous reset mid-packet.
    push_pkt(0, 5); push_pkt(2, 5);
    repeat (3) step(1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    drive_inputs();
    #1;
    chk("inflight_before_reset", o_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", o_valid, 0);
    chk("midreset_err", o_err, 0);
    chk("midreset_in_ready", rdy, 0);
    clear_model();
    drive_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < NB; b++) push_pkt(b, 2);
    drain(1'b1, n);
    chk("post_reset_first_src", seen_src.size() != 0 ? seen_src[0] : -1, 0);

    // Fixed priority instance.
    fp_mode = 1'b1;
    do_reset();
    chk_fp3 = 1'b1;
    repeat (5) push_pkt(1, 1);
    repeat (3) push_pkt(3, 1);
    drain(1'b0, n);
    chk_fp3 = 1'b0;
    chk("fp_seq_len", seen_src.size(), 8);
    for (int i = 0; i < 8 && i < seen_src.size(); i++) chk("fp_seq", seen_src[i], exp_fp[i]);
    repeat (10) begin
      for (int b = 0; b < NB; b++)
        repeat ($urandom_range(2)) push_pkt(b, $urandom_range(1, 6));
      drain(1'b1, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_buffer_selecter.md
# tx_buffer_selecter

Packet-level arbiter that merges NUM_BUFFERS transmit buffers onto the single transmitter flit stream, replacing the stub combinational selector. It grants one buffer at a time and holds the grant until that buffer's tail flit is accepted. Round-robin or fixed-priority arbitration is chosen by parameter. All output flits pass through one registered pipeline stage, and over-length packets are detected and dropped from the lock.

## Interface
Parameters:
- NUM_BUFFERS, 4: number of input tx buffers; 2..16.
- FLIT_WIDTH, 64: flit width in bits.
- MAX_PACKET_FLITS, 8: maximum legal flits per packet, head and tail included; ≥1.
- ROUND_ROBIN, 1: 1 selects round-robin; 0 selects fixed priority, lowest index wins.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  NUM_BUFFERS  per-buffer flit valid.
- in_flit  input  NUM_BUFFERS×FLIT_WIDTH  per-buffer flit; buffer i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_tail  input  NUM_BUFFERS  per-buffer tail flag; qualifies in_flit.
- in_ready  output  NUM_BUFFERS  per-buffer accept; one-hot or zero.
- out_valid  output  1  registered flit valid to the transmitter.
- out_flit  output  FLIT_WIDTH  registered flit.
- out_tail  output  1  registered tail flag.
- out_src  output  $clog2(NUM_BUFFERS)  index of the buffer that sourced out_flit.
- out_ready  input  1  transmitter accept.
- err_overlength  output  1  one-cycle pulse when a packet is truncated.

## Operation
- Handshake definitions:
  - Input transfer: in_valid[i] && in_ready[i].
  - Output transfer: out_valid && out_ready.
- Stage free: stage_free = !out_valid || out_ready.
- in_ready[i] = stage_free && (i == grant) && (state == LOCKED, or state == IDLE and i is the arbitration winner).
- FSM states: IDLE and LOCKED.
  - IDLE:
    - Arbitrate combinationally over in_valid.
    - Round-robin: search starts at index rr_ptr and wraps modulo NUM_BUFFERS.
    - Fixed priority: lowest asserted index wins.
    - If the winner transfers a non-tail flit: grant ← winner, go to LOCKED, flit_cnt ← 1.
    - If the winner transfers a tail flit (single-flit packet): stay in IDLE.
  - LOCKED:
    - Only in_ready[grant] may assert; other buffers stall regardless of in_valid.
    - Each transfer increments flit_cnt.
    - A tail transfer returns the FSM to IDLE.
- Round-robin pointer: on every tail transfer, rr_ptr ← (sourcing index + 1) mod NUM_BUFFERS. In fixed-priority mode rr_ptr is unused.
- Over-length packet:
  - Condition: in LOCKED, a non-tail transfer occurs while flit_cnt == MAX_PACKET_FLITS − 1.
  - The flit is forwarded with out_tail forced to 1.
  - err_overlength pulses for 1 cycle and the FSM returns to IDLE.
  - The buffer's remaining flits are arbitrated later as a new packet. Upstream owns recovery.
- Output stage:
  - On an input transfer: out_flit, out_tail and out_src load, and out_valid ← 1.
  - On an output transfer with no input transfer in the same cycle: out_valid ← 0.
  - Registered outputs hold steady while out_valid && !out_ready.
- Width rules:
  - flit_cnt is $clog2(MAX_PACKET_FLITS+1) bits and never wraps.
  - rr_ptr and grant are $clog2(NUM_BUFFERS) bits; the wrap is an explicit compare, not a power-of-two truncation.
- Reset values, all outputs and state:
  - out_valid=0, out_flit=0, out_tail=0, out_src=0, err_overlength=0.
  - state=IDLE, rr_ptr=0, grant=0, flit_cnt=0.
  - in_ready is combinational and reads 0 while rst is high.
- Reset mid-packet: all of the above state is cleared immediately (asynchronous). Any in-flight output flit is lost. The partial packet is not resumed.

## Timing
- Latency: a flit accepted at edge N appears on out_* after edge N. There is no additional bubble.
- Throughput: 1 flit per cycle when out_ready is held high, including back-to-back packets from different buffers. The IDLE re-arbitration after a tail happens in the same cycle.
- Backpressure: when out_ready=0 and out_valid=1, all in_ready are 0 in the same cycle, because in_ready depends combinationally on out_ready.
- Simultaneous events: an output transfer and a new input transfer in the same cycle keeps out_valid at 1 with the new data loaded.
- A tail transfer and an rr_ptr update occur on the same edge. A new grant may take effect on the next cycle.

## Test plan
- Reset: assert rst asynchronously mid-cycle with data in flight → out_valid, err_overlength and in_ready are 0 immediately; after release, the first grant goes to buffer 0.
- Round-robin fairness: NUM_BUFFERS=4, all buffers valid, 2-flit packets, out_ready=1 → out_src sequence is 0,0,1,1,2,2,3,3,0,0 with no idle cycles.
- Packet lock: buffer 2 sends a 3-flit packet while buffer 0 raises valid after the head → all 3 buffer-2 flits are contiguous; buffer 0 is granted next.
- Fixed priority: ROUND_ROBIN=0, buffers 1 and 3 continuously valid with 1-flit packets → out_src is always 1; in_ready[3] stays 0.
- Backpressure: hold out_ready=0 for 5 cycles mid-packet → out_flit is stable; in_ready is all zero; no flits lost or duplicated after release.
- Over-length: MAX_PACKET_FLITS=4, buffer 1 sends 6 non-tail flits → 4th flit has out_tail=1 and err_overlength pulses once; flits 5–6 start a new packet.
